gauss3x3_stream_ctrl: RTL and testbench
=======================================

# gauss3x3_stream_ctrl

Streaming sequencer for the 3×3 Gaussian kernel datapath (13-bit pixels, weights 1-2-1/2-4-2/1-2-1, ÷16). It accepts a raster-order pixel stream for one IMG_W×IMG_H frame, keeps two line buffers and a 3×3 window, drives the nine kernel operands with zero padding at image borders, and returns the kernel result as a backpressured output stream. It sits between the pixel source (frame memory reader) and the result writer, with one combinational kernel instance beside it.

## Interface
- IMG_W, 64, pixels per row (≥4)
- IMG_H, 64, rows per frame (≥3)
- PIX_W, 13, pixel width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  source has a pixel
- in_pixel  in  PIX_W  raster-order pixel
- in_ready  out  1  controller accepts in_pixel this cycle
- k_p0..k_p8  out  PIX_W each  window operands to kernel (p0 top-left … p8 bottom-right)
- k_result  in  PIX_W  kernel output, combinational from k_p*
- out_valid  out  1  out_pixel holds a filtered pixel
- out_pixel  out  PIX_W  filtered pixel, raster order
- out_ready  in  1  sink accepts out_pixel
- frame_done  out  1  one-cycle pulse after last output handshake

## Operation
- advance = (!out_valid || out_ready) && ((state∈{FILL,RUN} && in_valid) || state==FLUSH). in_ready = advance-condition without in_valid, in FILL/RUN only; forced 0 while rst_n low.
- Each advance shifts one sample (in_pixel, or 0 in FLUSH) into the window/line buffers. Line buffers: two depth-IMG_W shift memories giving rows r-1 and r for incoming row r+1.
- Input index i counts advances (0..IMG_W·IMG_H+IMG_W). Center of window is index i−(IMG_W+1) → output coordinate (orow, ocol), tracked by separate counters.
- Window: p0/p1/p2 = (orow−1, ocol−1/ocol/ocol+1), p3..p5 row orow, p6..p8 row orow+1.
- Zero padding: left column operands (p0,p3,p6) = 0 when ocol==0; right (p2,p5,p8) = 0 when ocol==IMG_W−1; top row = 0 when orow==0; bottom row = 0 when orow==IMG_H−1. Masks applied on k_p* combinationally.
- States: FILL (i < IMG_W+1; accept, no output) → RUN at i==IMG_W+1 (each advance loads out_pixel←k_result, out_valid←1) → FLUSH after last input accepted (in_ready=0, inject IMG_W+1 zero samples, still emitting) → DONE when last output handshakes (frame_done=1 one cycle) → FILL, counters and window cleared.
- Output register: on advance in RUN/FLUSH, load; else if out_ready clear out_valid. Holds stable while out_valid && !out_ready.
- Exactly IMG_W·IMG_H outputs per frame; no pixel dropped or duplicated under any in_valid/out_ready pattern.

## Timing
- Reset values: in_ready 0, out_valid 0, out_pixel 0, frame_done 0, k_p* 0; state FILL, all counters/buffers 0.
- First output: registered one cycle after the advance that accepts input index IMG_W+1 (pixel (1,1)).
- Throughput: one pixel/cycle with in_valid=out_ready=1; frame of 4096 pixels completes in 4096+65+1 cycles at defaults.
- Reset mid-frame: all state discarded immediately; next accepted pixel is (0,0) of a new frame.
- in_valid low in RUN: no advance, out_valid drops after current pixel is taken.
- frame_done asserts the cycle after the final out_valid&&out_ready; in_ready returns to 1 that same cycle.

## Structure
- Shared package: PIX_W, default IMG_W/IMG_H, state encoding (FILL, RUN, FLUSH, DONE).
- One sub-module natural: gauss_line_buffer (depth IMG_W, width PIX_W shift line, enable = advance), instantiated twice. kernel_3x3 instantiated by the parent, not inside this block.

## Test plan
- Constant 16 frame, always ready → interior 16, corner (0,0)=9, edge (0,5)=12, corner (63,63)=9; 4096 outputs, one frame_done.
- Impulse 1600 at (10,10), rest 0 → out (10,10)=400, (9,10)=200, (9,9)=100, (12,10)=0.
- Ramp in_pixel=col, random in_valid/out_ready (50%) → output sequence identical to always-ready run; out_pixel stable while stalled.
- out_ready low 20 cycles in RUN → in_ready 0 throughout, no input lost, out_pixel unchanged.
- rst_n low at pixel 2000, then new constant-8 frame → 4096 outputs all from new frame (interior 8), first output at (0,0).
- Two back-to-back frames → frame_done pulses twice, second frame's (0,0) unaffected by first frame's data.

Source files
------------

// File: rtl/gauss3x3_stream_ctrl_pkg.sv
// Shared constants for the 3x3 Gaussian stream sequencer: pixel width,
// default frame geometry and the sequencer state codes.
package gauss3x3_stream_ctrl_pkg;
    localparam int GAUSS_PIX_W = 13;
    localparam int GAUSS_IMG_W = 64;
    localparam int GAUSS_IMG_H = 64;

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/gauss3x3_stream_ctrl_line_buffer.sv
// One image row of delay: a DEPTH-deep shift line that moves only when en_i
// is high, so data_o is the sample written DEPTH enabled cycles earlier.
module gauss_line_buffer
    import gauss3x3_stream_ctrl_pkg::*;
#(
    parameter int DEPTH = GAUSS_IMG_W,
    parameter int WIDTH = GAUSS_PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);
    logic [WIDTH-1:0] lineMem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                lineMem_q[k] <= '0;
            end
        end else if (en_i) begin
            lineMem_q[0] <= data_i;
            for (int k = 1; k < DEPTH; k++) begin
                lineMem_q[k] <= lineMem_q[k-1];
            end
        end
    end

    assign data_o = lineMem_q[DEPTH-1];
endmodule

// File: rtl/gauss3x3_stream_ctrl.sv
// Raster-stream sequencer for a combinational 3x3 Gaussian kernel: line buffers,
// window, border masking of the operands and a backpressured result register.
module gauss3x3_stream_ctrl
    import gauss3x3_stream_ctrl_pkg::*;
#(
    parameter int IMG_W = GAUSS_IMG_W,
    parameter int IMG_H = GAUSS_IMG_H,
    parameter int PIX_W = GAUSS_PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    input  logic [PIX_W-1:0] in_pixel_i,
    output logic             in_ready_o,
    output logic [PIX_W-1:0] k_p0_o,
    output logic [PIX_W-1:0] k_p1_o,
    output logic [PIX_W-1:0] k_p2_o,
    output logic [PIX_W-1:0] k_p3_o,
    output logic [PIX_W-1:0] k_p4_o,
    output logic [PIX_W-1:0] k_p5_o,
    output logic [PIX_W-1:0] k_p6_o,
    output logic [PIX_W-1:0] k_p7_o,
    output logic [PIX_W-1:0] k_p8_o,
    input  logic [PIX_W-1:0] k_result_i,
    output logic             out_valid_o,
    output logic [PIX_W-1:0] out_pixel_o,
    input  logic             out_ready_i,
    output logic             frame_done_o
);
    localparam int IDX_END_I = IMG_W * IMG_H + IMG_W + 1;
    localparam int IDX_W     = $clog2(IDX_END_I + 1);
    localparam int COL_W     = $clog2(IMG_W);
    localparam int ROW_W     = $clog2(IMG_H);

    localparam logic [IDX_W-1:0] FILL_LAST = IDX_W'(IMG_W);
    localparam logic [IDX_W-1:0] IN_LAST   = IDX_W'(IMG_W * IMG_H - 1);
    localparam logic [IDX_W-1:0] IDX_END   = IDX_W'(IDX_END_I);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] inIdx_q, inIdx_d;
    logic [ROW_W-1:0] oRow_q, oRow_d;
    logic [COL_W-1:0] oCol_q, oCol_d;
    logic             outValid_q, outValid_d;
    logic [PIX_W-1:0] outPixel_q, outPixel_d;
    logic [PIX_W-1:0] leftCol_q [3];
    logic [PIX_W-1:0] leftCol_d [3];
    logic [PIX_W-1:0] midCol_q [3];
    logic [PIX_W-1:0] midCol_d [3];

    logic             acceptLike, emitting, slotFree, advance, lastHandshake;
    logic [PIX_W-1:0] sample, lb0Out, lb1Out;
    logic             keepTop, keepBot, keepLeft, keepRight;

    // DONE behaves like FILL for input so the next frame can start immediately.
    assign acceptLike    = (state_q == ST_FILL) || (state_q == ST_RUN) || (state_q == ST_DONE);
    assign emitting      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign slotFree      = !outValid_q || out_ready_i;
    assign in_ready_o    = rst_n && acceptLike && slotFree;
    assign advance       = slotFree && ((acceptLike && in_valid_i) ||
                                        ((state_q == ST_FLUSH) && (inIdx_q != IDX_END)));
    assign lastHandshake = (state_q == ST_FLUSH) && (inIdx_q == IDX_END) && outValid_q && out_ready_i;
    assign sample        = (state_q == ST_FLUSH) ? '0 : in_pixel_i;

    gauss_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (advance),
        .data_i (sample),
        .data_o (lb0Out)
    );

    gauss_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (advance),
        .data_i (lb0Out),
        .data_o (lb1Out)
    );

    // The right window column is the live line-buffer taps plus the incoming sample.
    assign keepTop   = emitting && (oRow_q != '0);
    assign keepBot   = emitting && (oRow_q != ROW_LAST);
    assign keepLeft  = (oCol_q != '0);
    assign keepRight = (oCol_q != COL_LAST);

    assign k_p0_o = (keepTop && keepLeft)   ? leftCol_q[0] : '0;
    assign k_p1_o = keepTop                 ? midCol_q[0]  : '0;
    assign k_p2_o = (keepTop && keepRight)  ? lb1Out       : '0;
    assign k_p3_o = (emitting && keepLeft)  ? leftCol_q[1] : '0;
    assign k_p4_o = emitting                ? midCol_q[1]  : '0;
    assign k_p5_o = (emitting && keepRight) ? lb0Out       : '0;
    assign k_p6_o = (keepBot && keepLeft)   ? leftCol_q[2] : '0;
    assign k_p7_o = keepBot                 ? midCol_q[2]  : '0;
    assign k_p8_o = (keepBot && keepRight)  ? sample       : '0;

    always_comb begin
        state_d    = state_q;
        inIdx_d    = inIdx_q;
        oRow_d     = oRow_q;
        oCol_d     = oCol_q;
        outValid_d = outValid_q;
        outPixel_d = outPixel_q;
        leftCol_d  = leftCol_q;
        midCol_d   = midCol_q;

        if (state_q == ST_DONE) begin
            state_d = ST_FILL;
        end

        if (advance) begin
            inIdx_d     = inIdx_q + IDX_W'(1);
            leftCol_d   = midCol_q;
            midCol_d[0] = lb1Out;
            midCol_d[1] = lb0Out;
            midCol_d[2] = sample;
            if (acceptLike && (inIdx_q == FILL_LAST)) begin
                state_d = ST_RUN;
            end
            if ((state_q == ST_RUN) && (inIdx_q == IN_LAST)) begin
                state_d = ST_FLUSH;
            end
            if (emitting) begin
                outPixel_d = k_result_i;
                outValid_d = 1'b1;
                if (oCol_q == COL_LAST) begin
                    oCol_d = '0;
                    oRow_d = (oRow_q == ROW_LAST) ? '0 : oRow_q + ROW_W'(1);
                end else begin
                    oCol_d = oCol_q + COL_W'(1);
                end
            end
        end else if (out_ready_i) begin
            outValid_d = 1'b0;
        end

        if (lastHandshake) begin
            state_d   = ST_DONE;
            inIdx_d   = '0;
            oRow_d    = '0;
            oCol_d    = '0;
            leftCol_d = '{default: '0};
            midCol_d  = '{default: '0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            inIdx_q    <= '0;
            oRow_q     <= '0;
            oCol_q     <= '0;
            outValid_q <= 1'b0;
            outPixel_q <= '0;
            leftCol_q  <= '{default: '0};
            midCol_q   <= '{default: '0};
        end else begin
            state_q    <= state_d;
            inIdx_q    <= inIdx_d;
            oRow_q     <= oRow_d;
            oCol_q     <= oCol_d;
            outValid_q <= outValid_d;
            outPixel_q <= outPixel_d;
            leftCol_q  <= leftCol_d;
            midCol_q   <= midCol_d;
        end
    end

    assign out_valid_o  = outValid_q;
    assign out_pixel_o  = outPixel_q;
    assign frame_done_o = (state_q == ST_DONE);
endmodule

// File: tb/tb_gauss3x3_stream_ctrl.sv
// Directed bench for gauss3x3_stream_ctrl with a behavioural 1-2-1 kernel
// and a direct zero-padded convolution as the reference.
module tb_gauss3x3_stream_ctrl;
    import gauss3x3_stream_ctrl_pkg::*;

    localparam int W      = 64;
    localparam int H      = 64;
    localparam int N      = W * H;
    localparam int PW     = GAUSS_PIX_W;
    localparam int BUDGET = 25000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, frame_done;
    logic [PW-1:0] in_pixel, out_pixel, k_result;
    logic [PW-1:0] k_p0, k_p1, k_p2, k_p3, k_p4, k_p5, k_p6, k_p7, k_p8;
    logic [16:0]   kSum;

    int compared   = 0;
    int mismatched = 0;
    int outMem [2*N];
    int refMem [N];
    int srcIdx, outCount, doneCount, iter, firstAcceptIter, firstOutIter, doneIter;
    int timedOut, stableViol, readyViol, doneReadyViol, doneWidthViol, stallInReady;
    int diffs;

    always #5 clk = ~clk;

    // Stand-in for the external kernel_3x3 instance.
    always_comb begin
        kSum = 17'(k_p0) + (17'(k_p1) << 1) + 17'(k_p2)
             + (17'(k_p3) << 1) + (17'(k_p4) << 2) + (17'(k_p5) << 1)
             + 17'(k_p6) + (17'(k_p7) << 1) + 17'(k_p8);
        k_result = kSum[16:4];
    end

    gauss3x3_stream_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid),
        .in_pixel_i   (in_pixel),
        .in_ready_o   (in_ready),
        .k_p0_o       (k_p0),
        .k_p1_o       (k_p1),
        .k_p2_o       (k_p2),
        .k_p3_o       (k_p3),
        .k_p4_o       (k_p4),
        .k_p5_o       (k_p5),
        .k_p6_o       (k_p6),
        .k_p7_o       (k_p7),
        .k_p8_o       (k_p8),
        .k_result_i   (k_result),
        .out_valid_o  (out_valid),
        .out_pixel_o  (out_pixel),
        .out_ready_i  (out_ready),
        .frame_done_o (frame_done)
    );

    function automatic int pixelFn(input int pat, input int r, input int c);
        case (pat)
            0:       return 16;
            1:       return (r == 10 && c == 10) ? 1600 : 0;
            2:       return c;
            3:       return 8;
            4:       return (r * 131 + c * 29 + r * c * 7) % 8192;
            default: return 4000;
        endcase
    endfunction

    function automatic int goldenFn(input int pat, input int r, input int c);
        int acc = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W) begin
                    acc += (dr == 0 ? 2 : 1) * (dc == 0 ? 2 : 1) * pixelFn(pat, r + dr, c + dc);
                end
            end
        end
        return acc / 16;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drives frames from pattern tables and records every output handshake.
    task automatic applyStimulus(input int patA, input int patB, input int nFrames, input int vProb,
                                 input int rProb, input int stallStart, input int stallLen, input int abortAt);
        int            localIdx;
        int            pat;
        bit            prevStall;
        bit            prevDone;
        bit            inStall;
        logic [PW-1:0] prevPix;
        srcIdx = 0; outCount = 0; doneCount = 0; iter = 0;
        firstAcceptIter = -1; firstOutIter = -1; doneIter = -1;
        timedOut = 0; stableViol = 0; readyViol = 0; doneReadyViol = 0; doneWidthViol = 0; stallInReady = 0;
        prevStall = 1'b0; prevDone = 1'b0; prevPix = '0;
        while (doneCount < nFrames && !(abortAt > 0 && srcIdx >= abortAt)) begin
            if (iter >= BUDGET * nFrames) begin
                timedOut = 1;
                break;
            end
            @(posedge clk);
            #1;
            inStall  = (iter >= stallStart) && (iter < stallStart + stallLen);
            pat      = (srcIdx < N) ? patA : patB;
            localIdx = srcIdx % N;
            in_valid = (srcIdx < nFrames * N) && ($urandom_range(99) < vProb);
            in_pixel = PW'(pixelFn(pat, localIdx / W, localIdx % W));
            out_ready = ($urandom_range(99) < rProb) && !inStall;
            @(negedge clk);
            if (prevStall && (!out_valid || out_pixel !== prevPix)) stableViol++;
            if (out_valid && !out_ready && in_ready) readyViol++;
            if (inStall && in_ready) stallInReady++;
            if (frame_done) begin
                if (!in_ready) doneReadyViol++;
                if (prevDone) doneWidthViol++;
                doneCount++;
                doneIter = iter;
            end
            if (out_valid && firstOutIter < 0) firstOutIter = iter;
            if (out_valid && out_ready) begin
                if (outCount < 2 * N) outMem[outCount] = int'(out_pixel);
                outCount++;
            end
            if (in_valid && in_ready) begin
                if (firstAcceptIter < 0) firstAcceptIter = iter;
                srcIdx++;
            end
            prevStall = out_valid && !out_ready;
            prevPix   = out_pixel;
            prevDone  = frame_done;
            iter++;
        end
        in_valid = 1'b0;
    endtask

    task automatic checkRun(input string tag, input int expFrames);
        checkOutput({tag, "_timeout"}, timedOut, 0);
        checkOutput({tag, "_count"}, outCount, expFrames * N);
        checkOutput({tag, "_frame_done"}, doneCount, expFrames);
        checkOutput({tag, "_protocol"}, stableViol + readyViol + doneReadyViol + doneWidthViol, 0);
    endtask

    task automatic checkFrame(input string tag, input int slot, input int pat);
        int errs = 0;
        for (int k = 0; k < N; k++) begin
            if (outMem[slot * N + k] != goldenFn(pat, k / W, k % W)) errs++;
        end
        checkOutput({tag, "_golden"}, errs, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;
        #2;
        in_valid = 1'b1;
        in_pixel = 13'd1234;
        #10;
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_pixel", out_pixel, 0);
        checkOutput("reset_frame_done", frame_done, 0);
        checkOutput("reset_kp", k_p0 | k_p1 | k_p2 | k_p3 | k_p4 | k_p5 | k_p6 | k_p7 | k_p8, 0);
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;

        $display("[TB] constant 16 frame, always ready");
        applyStimulus(0, 0, 1, 100, 100, 0, 0, 0);
        checkRun("const16", 1);
        checkFrame("const16", 0, 0);
        checkOutput("const16_corner_0_0", outMem[0], 9);
        checkOutput("const16_edge_0_5", outMem[5], 12);
        checkOutput("const16_corner_63_63", outMem[63 * W + 63], 9);
        checkOutput("const16_interior", outMem[30 * W + 30], 16);
        checkOutput("first_out_latency", firstOutIter - firstAcceptIter, W + 2);
        checkOutput("frame_cycles", doneIter - firstAcceptIter, N + W + 2);

        $display("[TB] ramp frame, always ready");
        applyStimulus(2, 2, 1, 100, 100, 0, 0, 0);
        checkRun("ramp", 1);
        checkFrame("ramp", 0, 2);
        checkOutput("ramp_5_10", outMem[5 * W + 10], 10);
        checkOutput("ramp_5_63", outMem[5 * W + 63], 47);
        checkOutput("ramp_0_63", outMem[63], 35);
        checkOutput("ramp_5_0", outMem[5 * W], 0);
        for (int k = 0; k < N; k++) refMem[k] = outMem[k];

        $display("[TB] ramp frame, random valid/ready");
        applyStimulus(2, 2, 1, 50, 50, 0, 0, 0);
        checkRun("ramp_rand", 1);
        diffs = 0;
        for (int k = 0; k < N; k++) begin
            if (outMem[k] != refMem[k]) diffs++;
        end
        checkOutput("ramp_rand_vs_ready", diffs, 0);

        $display("[TB] textured frame with 20-cycle output stall");
        applyStimulus(4, 4, 1, 100, 100, 300, 20, 0);
        checkRun("stall", 1);
        checkFrame("stall", 0, 4);
        checkOutput("stall_in_ready", stallInReady, 0);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(4, 4, 1, 100, 100, 0, 0, 2000);
        rst_n = 1'b0;
        #2;
        checkOutput("midreset_in_ready", in_ready, 0);
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_frame_done", frame_done, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        applyStimulus(3, 3, 1, 100, 100, 0, 0, 0);
        checkRun("const8", 1);
        checkFrame("const8", 0, 3);
        checkOutput("const8_corner_0_0", outMem[0], 4);
        checkOutput("const8_edge_0_5", outMem[5], 6);
        checkOutput("const8_interior", outMem[5 * W + 5], 8);

        $display("[TB] two back-to-back frames");
        applyStimulus(5, 1, 2, 100, 100, 0, 0, 0);
        checkRun("b2b", 2);
        checkFrame("b2b_f0", 0, 5);
        checkFrame("b2b_f1", 1, 1);
        checkOutput("b2b_f0_interior", outMem[100], 4000);
        checkOutput("b2b_f1_corner_0_0", outMem[N], 0);
        checkOutput("impulse_10_10", outMem[N + 10 * W + 10], 400);
        checkOutput("impulse_9_10", outMem[N + 9 * W + 10], 200);
        checkOutput("impulse_9_9", outMem[N + 9 * W + 9], 100);
        checkOutput("impulse_12_10", outMem[N + 12 * W + 10], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
